// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory access stage: FSM states,
// one-hot ExtType bit positions and bus size codes.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_DRAIN     = 2'd3
  } mem_state_e;

  // E_ExtType is one-hot {lb,lbu,lh,lhu,lw,lwl,lwr,swl,swr}, lb in the MSB
  localparam int EXT_LB  = 8;
  localparam int EXT_LBU = 7;
  localparam int EXT_LH  = 6;
  localparam int EXT_LHU = 5;
  localparam int EXT_LW  = 4;
  localparam int EXT_LWL = 3;
  localparam int EXT_LWR = 2;
  localparam int EXT_SWL = 1;
  localparam int EXT_SWR = 0;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data SRAM request/response bus (req/addr_ok address phase, data_ok data phase).
interface mem_access_stage_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wdata, data_sram_wstrb,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wdata, data_sram_wstrb,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/mem_load_align.sv
// Load data extract/extend, plus lwl/lwr register merge when MEM_UNALIGNED_LR_EN
// is defined (little-endian byte numbering, off = address low bits).
module mem_load_align
  import mem_pkg::*;
(
  input  logic [8:0]  ext_type,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] rt,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        unused_bits;

  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    if (ext_type[EXT_LB]) begin
      result = {{24{byte_sel[7]}}, byte_sel};
    end else if (ext_type[EXT_LBU]) begin
      result = {24'd0, byte_sel};
    end else if (ext_type[EXT_LH]) begin
      result = {{16{half_sel[15]}}, half_sel};
    end else if (ext_type[EXT_LHU]) begin
      result = {16'd0, half_sel};
`ifdef MEM_UNALIGNED_LR_EN
    end else if (ext_type[EXT_LWL]) begin
      // memory bytes fill the register from the top down
      case (off)
        2'd0:    result = {rdata[7:0],  rt[23:0]};
        2'd1:    result = {rdata[15:0], rt[15:0]};
        2'd2:    result = {rdata[23:0], rt[7:0]};
        default: result = rdata;
      endcase
    end else if (ext_type[EXT_LWR]) begin
      case (off)
        2'd1:    result = {rt[31:24], rdata[31:8]};
        2'd2:    result = {rt[31:16], rdata[31:16]};
        2'd3:    result = {rt[31:8],  rdata[31:24]};
        default: result = rdata;
      endcase
`endif
    end
  end

`ifdef MEM_UNALIGNED_LR_EN
  assign unused_bits = ^{ext_type[EXT_LW], ext_type[EXT_SWL], ext_type[EXT_SWR]};
`else
  assign unused_bits = ^{ext_type[EXT_LW], ext_type[EXT_LWL], ext_type[EXT_LWR],
                         ext_type[EXT_SWL], ext_type[EXT_SWR], rt};
`endif

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data SRAM requests for E, stalls until data_ok,
// and loads the M registers. Optional feature macro: MEM_UNALIGNED_LR_EN.
module mem_access_stage
  import mem_pkg::*;
(
  input  logic                      Clk,
  input  logic                      Clr_n,
  input  logic                      exp_flush,
  input  logic [31:0]               E_PC,
  input  logic [31:0]               E_Data,
  input  logic [31:0]               E_WriteMemData,
  input  logic [3:0]                E_T,
  input  logic                      E_WriteRegEnable,
  input  logic [4:0]                E_RegId,
  input  logic [8:0]                E_ExtType,
  input  logic [3:0]                E_MemWriteEnable,
  input  logic                      E_MemReadEnable,
  input  logic                      E_data_alignment_err,
  mem_access_stage_if.master        data_sram,
  output logic                      dm_stall,
  output logic [31:0]               M_PC,
  output logic [31:0]               M_Data,
  output logic [3:0]                M_T,
  output logic                      M_WriteRegEnable,
  output logic [4:0]                M_RegId,
  output logic                      M_data_alignment_err,
  output logic                      M_inst_invalid
);

  mem_state_e  state_q, state_d;
  logic        lr_blocked;
  logic        mem_op;
  logic        data_done;
  logic [1:0]  off;
  logic [1:0]  size;
  logic [31:0] load_result;

  logic [31:0] m_pc_q, m_pc_d, m_data_q, m_data_d;
  logic [3:0]  m_t_q, m_t_d;
  logic        m_wre_q, m_wre_d, m_align_q, m_align_d, m_inv_q, m_inv_d;
  logic [4:0]  m_regid_q, m_regid_d;

  assign off = E_Data[1:0];

`ifdef MEM_UNALIGNED_LR_EN
  assign lr_blocked = 1'b0;
`else
  assign lr_blocked = E_ExtType[EXT_LWL] | E_ExtType[EXT_LWR] |
                      E_ExtType[EXT_SWL] | E_ExtType[EXT_SWR];
`endif

  assign mem_op = (E_MemReadEnable || (E_MemWriteEnable != 4'd0)) &&
                  !E_data_alignment_err && !lr_blocked && !exp_flush;
  assign data_done = (state_q == ST_WAIT_DATA) && data_sram.data_sram_data_ok;

  // Plain stores carry no ExtType bit, so their size comes from the strobes
  always_comb begin
    size = SIZE_WORD;
    if (E_MemReadEnable) begin
      if (E_ExtType[EXT_LB] || E_ExtType[EXT_LBU])      size = SIZE_BYTE;
      else if (E_ExtType[EXT_LH] || E_ExtType[EXT_LHU]) size = SIZE_HALF;
      else                                              size = SIZE_WORD;
    end else if (!(E_ExtType[EXT_SWL] || E_ExtType[EXT_SWR])) begin
      case (E_MemWriteEnable)
        4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
        4'b0011, 4'b1100:                   size = SIZE_HALF;
        default:                            size = SIZE_WORD;
      endcase
    end
  end

  always_comb begin
    case (size)
      SIZE_BYTE: data_sram.data_sram_wdata = {4{E_WriteMemData[7:0]}};
      SIZE_HALF: data_sram.data_sram_wdata = {2{E_WriteMemData[15:0]}};
      default:   data_sram.data_sram_wdata = E_WriteMemData;
    endcase
`ifdef MEM_UNALIGNED_LR_EN
    if (E_ExtType[EXT_SWL])
      data_sram.data_sram_wdata = E_WriteMemData >> {2'd3 - off, 3'b000};
    else if (E_ExtType[EXT_SWR])
      data_sram.data_sram_wdata = E_WriteMemData << {off, 3'b000};
`endif
  end

  assign data_sram.data_sram_size  = size;
  assign data_sram.data_sram_addr  = (size == SIZE_WORD) ? {E_Data[31:2], 2'b00} : E_Data;
  assign data_sram.data_sram_wstrb = E_MemWriteEnable;
  assign data_sram.data_sram_wr    = (E_MemWriteEnable != 4'd0);

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && data_sram.data_sram_addr_ok) state_d = ST_WAIT_DATA;
        else if (mem_op)                           state_d = ST_REQ;
      end
      ST_REQ: begin
        // a flushed request already accepted must still have its data drained
        if (data_sram.data_sram_addr_ok) state_d = exp_flush ? ST_DRAIN : ST_WAIT_DATA;
        else if (exp_flush)              state_d = ST_IDLE;
      end
      ST_WAIT_DATA: begin
        if (data_sram.data_sram_data_ok) state_d = ST_IDLE;
        else if (exp_flush)              state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (data_sram.data_sram_data_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_sram.data_sram_req = 1'b0;
    dm_stall                = 1'b0;
    if (Clr_n) begin
      data_sram.data_sram_req = ((state_q == ST_IDLE) && mem_op) || (state_q == ST_REQ);
      dm_stall                = (mem_op && !data_done) || (state_q == ST_DRAIN);
    end
  end

  mem_load_align u_load_align (
    .ext_type (E_ExtType),
    .off      (off),
    .rdata    (data_sram.data_sram_rdata),
    .rt       (E_WriteMemData),
    .result   (load_result)
  );

  always_comb begin
    m_pc_d    = E_PC;
    m_t_d     = (E_T != 4'd0) ? E_T - 4'd1 : 4'd0;
    m_wre_d   = E_WriteRegEnable && !lr_blocked;
    m_regid_d = E_RegId;
    m_data_d  = (E_MemReadEnable && !E_data_alignment_err && !lr_blocked) ? load_result : E_Data;
    m_align_d = E_data_alignment_err;
    m_inv_d   = lr_blocked;
    if (exp_flush) begin
      m_pc_d    = 32'd0;
      m_t_d     = 4'd0;
      m_wre_d   = 1'b0;
      m_regid_d = 5'd0;
      m_data_d  = 32'd0;
      m_align_d = 1'b0;
      m_inv_d   = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      m_pc_q    <= 32'd0;
      m_t_q     <= 4'd0;
      m_wre_q   <= 1'b0;
      m_regid_q <= 5'd0;
      m_data_q  <= 32'd0;
      m_align_q <= 1'b0;
      m_inv_q   <= 1'b0;
    end else if (!dm_stall) begin
      m_pc_q    <= m_pc_d;
      m_t_q     <= m_t_d;
      m_wre_q   <= m_wre_d;
      m_regid_q <= m_regid_d;
      m_data_q  <= m_data_d;
      m_align_q <= m_align_d;
      m_inv_q   <= m_inv_d;
    end
  end

  assign M_PC                 = m_pc_q;
  assign M_Data               = m_data_q;
  assign M_T                  = m_t_q;
  assign M_WriteRegEnable     = m_wre_q;
  assign M_RegId              = m_regid_q;
  assign M_data_alignment_err = m_align_q;
  assign M_inst_invalid       = m_inv_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; expected values are hand-computed.
module tb_mem_access_stage;

  localparam logic [8:0] X_NONE = 9'h000;
  localparam logic [8:0] X_LB   = 9'h100;
  localparam logic [8:0] X_LBU  = 9'h080;
  localparam logic [8:0] X_LH   = 9'h040;
  localparam logic [8:0] X_LHU  = 9'h020;
  localparam logic [8:0] X_LW   = 9'h010;
  localparam logic [8:0] X_LWL  = 9'h008;
  localparam logic [8:0] X_LWR  = 9'h004;
  localparam logic [8:0] X_SWL  = 9'h002;

  logic        Clk, Clr_n, exp_flush;
  logic [31:0] E_PC, E_Data, E_WriteMemData;
  logic [3:0]  E_T, E_MemWriteEnable;
  logic        E_WriteRegEnable, E_MemReadEnable, E_data_alignment_err;
  logic [4:0]  E_RegId;
  logic [8:0]  E_ExtType;
  logic        dm_stall;
  logic [31:0] M_PC, M_Data;
  logic [3:0]  M_T;
  logic        M_WriteRegEnable, M_data_alignment_err, M_inst_invalid;
  logic [4:0]  M_RegId;

  int n_total = 0;
  int n_pass  = 0;

  mem_access_stage_if bus ();

  mem_access_stage dut (
    .Clk                  (Clk),
    .Clr_n                (Clr_n),
    .exp_flush            (exp_flush),
    .E_PC                 (E_PC),
    .E_Data               (E_Data),
    .E_WriteMemData       (E_WriteMemData),
    .E_T                  (E_T),
    .E_WriteRegEnable     (E_WriteRegEnable),
    .E_RegId              (E_RegId),
    .E_ExtType            (E_ExtType),
    .E_MemWriteEnable     (E_MemWriteEnable),
    .E_MemReadEnable      (E_MemReadEnable),
    .E_data_alignment_err (E_data_alignment_err),
    .data_sram            (bus),
    .dm_stall             (dm_stall),
    .M_PC                 (M_PC),
    .M_Data               (M_Data),
    .M_T                  (M_T),
    .M_WriteRegEnable     (M_WriteRegEnable),
    .M_RegId              (M_RegId),
    .M_data_alignment_err (M_data_alignment_err),
    .M_inst_invalid       (M_inst_invalid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_nop();
    exp_flush = 1'b0; E_PC = 32'd0; E_Data = 32'd0; E_WriteMemData = 32'd0;
    E_T = 4'd0; E_WriteRegEnable = 1'b0; E_RegId = 5'd0; E_ExtType = X_NONE;
    E_MemWriteEnable = 4'd0; E_MemReadEnable = 1'b0; E_data_alignment_err = 1'b0;
    bus.data_sram_addr_ok = 1'b0; bus.data_sram_data_ok = 1'b0; bus.data_sram_rdata = 32'd0;
  endtask

  task automatic set_e(input logic [31:0] pc, input logic [31:0] data, input logic [31:0] rt,
                       input logic [8:0] ext, input logic [3:0] we, input logic re,
                       input logic [4:0] rid, input logic [3:0] t);
    E_PC = pc; E_Data = data; E_WriteMemData = rt; E_ExtType = ext;
    E_MemWriteEnable = we; E_MemReadEnable = re; E_RegId = rid; E_T = t;
    E_WriteRegEnable = re; E_data_alignment_err = 1'b0;
  endtask

  // address accepted in the request cycle, data_ok in the following cycle
  task automatic do_load(input string tag, input logic [31:0] data, input logic [31:0] rt,
                         input logic [8:0] ext, input logic [31:0] rdata,
                         input logic [31:0] exp_data);
    set_e(32'h1000, data, rt, ext, 4'd0, 1'b1, 5'd9, 4'd3);
    bus.data_sram_addr_ok = 1'b1;
    #1;
    check({tag, "_req"}, 32'(bus.data_sram_req), 32'd1);
    tick();
    bus.data_sram_addr_ok = 1'b0; bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = rdata;
    tick();
    check({tag, "_mdata"}, M_Data, exp_data);
    set_nop();
  endtask

  task automatic do_store(input string tag, input logic [31:0] data, input logic [31:0] rt,
                          input logic [8:0] ext, input logic [3:0] we,
                          input logic [31:0] exp_wdata, input logic [1:0] exp_size,
                          input logic [31:0] exp_addr);
    set_e(32'h2000, data, rt, ext, we, 1'b0, 5'd0, 4'd0);
    bus.data_sram_addr_ok = 1'b1;
    #1;
    check({tag, "_wdata"}, bus.data_sram_wdata, exp_wdata);
    check({tag, "_wstrb"}, 32'(bus.data_sram_wstrb), 32'(we));
    check({tag, "_size"},  32'(bus.data_sram_size), 32'(exp_size));
    check({tag, "_wr"},    32'(bus.data_sram_wr), 32'd1);
    check({tag, "_addr"},  bus.data_sram_addr, exp_addr);
    tick();
    bus.data_sram_addr_ok = 1'b0; bus.data_sram_data_ok = 1'b1;
    tick();
    check({tag, "_mdata"}, M_Data, data);
    set_nop();
  endtask

  initial begin
    set_nop();
    Clr_n = 1'b0;
    set_e(32'h44, 32'h100, 32'd0, X_LW, 4'd0, 1'b1, 5'd1, 4'd1);
    repeat (2) @(posedge Clk);
    #1;
    check("rst_req",   32'(bus.data_sram_req), 32'd0);
    check("rst_stall", 32'(dm_stall), 32'd0);
    check("rst_mpc",   M_PC, 32'd0);
    check("rst_mdata", M_Data, 32'd0);
    set_nop();
    Clr_n = 1'b1;
    tick();

    // lw with zero address wait: one stall cycle
    set_e(32'h400, 32'h100, 32'd0, X_LW, 4'd0, 1'b1, 5'd5, 4'd2);
    bus.data_sram_addr_ok = 1'b1;
    #1;
    check("lw_req",    32'(bus.data_sram_req), 32'd1);
    check("lw_addr",   bus.data_sram_addr, 32'h100);
    check("lw_size",   32'(bus.data_sram_size), 32'd2);
    check("lw_wr",     32'(bus.data_sram_wr), 32'd0);
    check("lw_stall0", 32'(dm_stall), 32'd1);
    tick();
    bus.data_sram_addr_ok = 1'b0; bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'hDEADBEEF;
    #1;
    check("lw_req1",   32'(bus.data_sram_req), 32'd0);
    check("lw_stall1", 32'(dm_stall), 32'd0);
    tick();
    check("lw_mdata",  M_Data, 32'hDEADBEEF);
    check("lw_mpc",    M_PC, 32'h400);
    check("lw_mt",     32'(M_T), 32'd1);
    check("lw_mrid",   32'(M_RegId), 32'd5);
    check("lw_mwre",   32'(M_WriteRegEnable), 32'd1);
    set_nop();
    #1;
    check("lw_stall2", 32'(dm_stall), 32'd0);

    do_load("lb",  32'h103, 32'd0, X_LB,  32'h80112233, 32'hFFFFFF80);
    do_load("lbu", 32'h103, 32'd0, X_LBU, 32'h80112233, 32'h00000080);
    do_load("lh",  32'h102, 32'd0, X_LH,  32'h80112233, 32'hFFFF8011);
    do_load("lhu", 32'h100, 32'd0, X_LHU, 32'h80112233, 32'h00002233);

    do_store("sh", 32'h202, 32'h1234ABCD, X_NONE, 4'b1100, 32'hABCDABCD, 2'd1, 32'h202);
    do_store("sb", 32'h201, 32'h000000EF, X_NONE, 4'b0010, 32'hEFEFEFEF, 2'd0, 32'h201);
    do_store("sw", 32'h300, 32'h0BADF00D, X_NONE, 4'b1111, 32'h0BADF00D, 2'd2, 32'h300);

    // addr_ok held off for 3 cycles
    set_e(32'h500, 32'h500, 32'd0, X_LW, 4'd0, 1'b1, 5'd6, 4'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("dly_req%0d", i),   32'(bus.data_sram_req), 32'd1);
      check($sformatf("dly_addr%0d", i),  bus.data_sram_addr, 32'h500);
      check($sformatf("dly_stall%0d", i), 32'(dm_stall), 32'd1);
      tick();
    end
    bus.data_sram_addr_ok = 1'b1;
    #1;
    check("dly_req3", 32'(bus.data_sram_req), 32'd1);
    tick();
    bus.data_sram_addr_ok = 1'b0; bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'hCAFEF00D;
    #1;
    check("dly_stall4", 32'(dm_stall), 32'd0);
    tick();
    check("dly_mdata", M_Data, 32'hCAFEF00D);
    set_nop();

    // flush while waiting for data, then a new lw behind the stale response
    set_e(32'h600, 32'h600, 32'd0, X_LW, 4'd0, 1'b1, 5'd2, 4'd0);
    bus.data_sram_addr_ok = 1'b1;
    tick();
    bus.data_sram_addr_ok = 1'b0; exp_flush = 1'b1;
    #1;
    check("fl_stall", 32'(dm_stall), 32'd0);
    tick();
    check("fl_bubble_pc", M_PC, 32'd0);
    check("fl_bubble_wre", 32'(M_WriteRegEnable), 32'd0);
    exp_flush = 1'b0;
    set_e(32'h700, 32'h700, 32'd0, X_LW, 4'd0, 1'b1, 5'd7, 4'd0);
    #1;
    check("fl_drain_req", 32'(bus.data_sram_req), 32'd0);
    check("fl_drain_stall", 32'(dm_stall), 32'd1);
    tick();
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'hBAD0BAD0;
    #1;
    check("fl_stale_req", 32'(bus.data_sram_req), 32'd0);
    check("fl_stale_stall", 32'(dm_stall), 32'd1);
    tick();
    check("fl_stale_mpc", M_PC, 32'd0);
    bus.data_sram_data_ok = 1'b0; bus.data_sram_addr_ok = 1'b1;
    #1;
    check("fl_new_req", 32'(bus.data_sram_req), 32'd1);
    check("fl_new_addr", bus.data_sram_addr, 32'h700);
    tick();
    bus.data_sram_addr_ok = 1'b0; bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h12345678;
    tick();
    check("fl_new_mdata", M_Data, 32'h12345678);
    check("fl_new_mpc", M_PC, 32'h700);
    set_nop();

`ifdef MEM_UNALIGNED_LR_EN
    set_e(32'h800, 32'h101, 32'h11223344, X_LWL, 4'd0, 1'b1, 5'd3, 4'd0);
    #1;
    check("lwl_addr", bus.data_sram_addr, 32'h100);
    check("lwl_size", 32'(bus.data_sram_size), 32'd2);
    set_nop();
    do_load("lwl", 32'h101, 32'h11223344, X_LWL, 32'hAABBCCDD, 32'hCCDD3344);
    check("lwl_inv", 32'(M_inst_invalid), 32'd0);
    do_load("lwr", 32'h101, 32'h11223344, X_LWR, 32'hAABBCCDD, 32'h11AABBCC);
    do_store("swl", 32'h101, 32'h11223344, X_SWL, 4'b0011, 32'h00001122, 2'd2, 32'h100);
`else
    set_e(32'h800, 32'h101, 32'h11223344, X_LWL, 4'd0, 1'b1, 5'd3, 4'd0);
    #1;
    check("lwl_req", 32'(bus.data_sram_req), 32'd0);
    check("lwl_stall", 32'(dm_stall), 32'd0);
    tick();
    check("lwl_inv", 32'(M_inst_invalid), 32'd1);
    check("lwl_wre", 32'(M_WriteRegEnable), 32'd0);
    set_nop();
`endif

    // alignment error suppresses the request
    set_e(32'h900, 32'h102, 32'd0, X_LW, 4'd0, 1'b1, 5'd4, 4'd0);
    E_data_alignment_err = 1'b1;
    #1;
    check("ae_req", 32'(bus.data_sram_req), 32'd0);
    check("ae_stall", 32'(dm_stall), 32'd0);
    tick();
    check("ae_merr", 32'(M_data_alignment_err), 32'd1);
    check("ae_mdata", M_Data, 32'h102);
    set_nop();

    // ALU op with T already 0 saturates
    set_e(32'hA00, 32'h55, 32'd0, X_NONE, 4'd0, 1'b0, 5'd8, 4'd0);
    tick();
    check("alu_mt", 32'(M_T), 32'd0);
    check("alu_mdata", M_Data, 32'h55);
    check("alu_mpc", M_PC, 32'hA00);
    set_nop();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Clk  in  1  sole clock; all state updates on posedge Clk.
REQ-002 Clr_n  in  1  reset, asynchronous, active-low.
REQ-003 exp_flush  in  1  cancel the instruction currently in E and the M registers.
REQ-004 E_PC, E_Data, E_WriteMemData  in  32 each  PC; ALU result / load-store address; store data (forwarded rt).
REQ-005 E_T  in  4; E_WriteRegEnable  in  1; E_RegId  in  5  forwarding tag fields from E.
REQ-006 E_ExtType  in  9  one-hot {lb,lbu,lh,lhu,lw,lwl,lwr,swl,swr}; E_MemWriteEnable  in  4  byte strobes; E_MemReadEnable  in  1; E_data_alignment_err  in  1.
REQ-007 data_sram_req  out  1; data_sram_wr  out  1; data_sram_size  out  2; data_sram_addr  out  32; data_sram_wdata  out  32; data_sram_wstrb  out  4.
REQ-008 data_sram_addr_ok  in  1; data_sram_data_ok  in  1; data_sram_rdata  in  32.
REQ-009 dm_stall  out  1  freeze E and upstream.
REQ-010 M_PC, M_Data  out  32; M_T  out  4; M_WriteRegEnable  out  1; M_RegId  out  5; M_data_alignment_err, M_inst_invalid  out  1 each.

Function
REQ-011 mem_op = (E_MemReadEnable or E_MemWriteEnable != 0) and !E_data_alignment_err and !exp_flush.
REQ-012 FSM states IDLE, REQ, WAIT_DATA, DRAIN; reset state IDLE.
REQ-013 IDLE: data_sram_req = mem_op; addr_ok high -> WAIT_DATA, else -> REQ if mem_op.
REQ-014 REQ: req held high, addr/size/wr/wdata/wstrb stable; addr_ok -> WAIT_DATA.
REQ-015 WAIT_DATA: req low; data_ok -> IDLE and M registers load; data_ok in the addr_ok cycle is ignored.
REQ-016 dm_stall = mem_op and !(state==WAIT_DATA and data_ok), or state==DRAIN; load-to-use minimum: request cycle plus one wait cycle.
REQ-017 exp_flush in REQ or WAIT_DATA after addr_ok -> DRAIN; DRAIN holds req low until data_ok, discards rdata, -> IDLE; exp_flush in REQ before addr_ok -> IDLE directly.
REQ-018 Address: data_sram_addr = E_Data, low two bits forced 0 for lw/lwl/lwr/sw/swl/swr; size 0 byte, 1 half, 2 word (lwl/lwr/swl/swr use 2).
REQ-019 wdata: sb byte replicated x4, sh half replicated x2, sw as-is, swl E_WriteMemData >> 8*(3-off), swr << 8*off; off = E_Data[1:0]; wstrb = E_MemWriteEnable; wr = (wstrb != 0).
REQ-020 Load result: lb/lbu sign/zero-extended byte off, lh/lhu half at off[1], lw word, lwl/lwr merge rdata with E_WriteMemData per MIPS32 byte rules.
REQ-021 M update when !dm_stall: M_PC<=E_PC, M_T<=(E_T>0?E_T-1:0), M_WriteRegEnable, M_RegId, M_Data<=load result or E_Data, M_data_alignment_err<=E_data_alignment_err.
REQ-022 exp_flush with !dm_stall: M registers load zeros (bubble).

Reset
REQ-023 Clr_n low: state IDLE, all M_* outputs 0, data_sram_req 0, dm_stall 0, regardless of outstanding transaction; first data_ok after release is discarded only if state is DRAIN.

Configuration
REQ-024 MEM_UNALIGNED_LR_EN defined: lwl/lwr/swl/swr execute per REQ-019/020.
REQ-025 MEM_UNALIGNED_LR_EN undefined: those four issue no request, M_inst_invalid<=1, M_WriteRegEnable<=0; merge logic absent.

Structure
REQ-026 Package mem_pkg holds FSM state enum, ExtType bit indices, size codes 0/1/2.
REQ-027 Combinational sub-module mem_load_align performs REQ-020 extract/extend/merge.

Verification
REQ-028 lw, E_Data=0x100, addr_ok same cycle, data_ok 1 cycle later, rdata=0xDEADBEEF -> M_Data=0xDEADBEEF, dm_stall high exactly 1 cycle.
REQ-029 lb, E_Data=0x103, rdata=0x80112233 -> M_Data=0xFFFFFF80; lbu same -> 0x00000080.
REQ-030 sh, E_Data=0x202, rt=0x1234ABCD -> wdata=0xABCDABCD, wstrb=4'b1100, size=1, wr=1.
REQ-031 addr_ok delayed 3 cycles -> req and addr/wdata stable all 3 cycles, dm_stall held.
REQ-032 exp_flush in WAIT_DATA, then lw in E -> no req until stale data_ok, stale rdata discarded, new lw completes correctly.
REQ-033 lwl, off=1, rt=0x11223344, rdata=0xAABBCCDD, macro on -> M_Data=0xCCDD3344; macro off -> no req, M_inst_invalid=1.
